// File: rtl/ring_pkg.sv
// Shared definitions for the 2-of-5 buffer position ring sequencer:
// command opcodes, the ten digit codes and code helper functions.
package ring_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_CLEAR = 2'b01,
        OP_STEP  = 2'b10,
        OP_SEEK  = 2'b11
    } op_t;

    // Digit codes as {a,b,c,d,e}; exactly two bits set in every valid code
    localparam logic [4:0] CODE0 = 5'b00011;
    localparam logic [4:0] CODE1 = 5'b10010;
    localparam logic [4:0] CODE2 = 5'b10001;
    localparam logic [4:0] CODE3 = 5'b01001;
    localparam logic [4:0] CODE4 = 5'b11000;
    localparam logic [4:0] CODE5 = 5'b10100;
    localparam logic [4:0] CODE6 = 5'b01100;
    localparam logic [4:0] CODE7 = 5'b01010;
    localparam logic [4:0] CODE8 = 5'b00110;
    localparam logic [4:0] CODE9 = 5'b00101;

    function automatic logic is_2of5(input logic [4:0] c);
        return ($countones(c) == 2);
    endfunction

    // Code a decade counter shows after one advance; 9 wraps to 0
    function automatic logic [4:0] next_code(input logic [4:0] c);
        logic [4:0] n;
        case (c)
            CODE0:   n = CODE1;
            CODE1:   n = CODE2;
            CODE2:   n = CODE3;
            CODE3:   n = CODE4;
            CODE4:   n = CODE5;
            CODE5:   n = CODE6;
            CODE6:   n = CODE7;
            CODE7:   n = CODE8;
            CODE8:   n = CODE9;
            default: n = CODE0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ring_step_ctl.sv
// Sequencer for a two-digit 2-of-5 position ring made of two edge-triggered
// decade counters. Executes CLEAR / STEP_N / SEEK commands by pulsing the
// counters' set0/advance inputs, generating the tens carry alongside the
// units advance when the units digit reads 9.
// Optional feature: define RING_STEP_CHECK_EN to verify the counter feedback
// against a predicted code after every pulse and after a clear.
module ring_step_ctl
    import ring_pkg::*;
#(
    parameter int unsigned SEEK_LIMIT = 100
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [9:0] i_cmd_arg,
    input  logic [4:0] i_units,
    input  logic [4:0] i_tens,
    output logic       o_units_set0,
    output logic       o_units_advance,
    output logic       o_tens_set0,
    output logic       o_tens_advance,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    localparam int unsigned PW = $clog2(SEEK_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_PULSE,
        S_WAIT,
        S_CLR,
        S_CWAIT,
        S_DONE
    } state_t;

    state_t         state;
    op_t            op_q;
    logic [6:0]     remaining;
    logic [PW-1:0]  pulse_cnt;
    logic [4:0]     target_units;
    logic [4:0]     target_tens;
`ifdef RING_STEP_CHECK_EN
    logic [4:0]     pred_units;
    logic [4:0]     pred_tens;
    logic           accept_bad;
`endif

    // Command sequencer; every output is a register updated with the state.
    // Pulse outputs default low so each strobe lasts exactly one cycle, and
    // the PULSE->WAIT->EVAL loop guarantees two low cycles between advances.
    // o_done is raised on the DONE->IDLE edge so it coincides with ready.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= S_IDLE;
            op_q            <= OP_NOP;
            remaining       <= '0;
            pulse_cnt       <= '0;
            target_units    <= '0;
            target_tens     <= '0;
            o_cmd_ready     <= 1'b1;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
            o_units_set0    <= 1'b0;
            o_units_advance <= 1'b0;
            o_tens_set0     <= 1'b0;
            o_tens_advance  <= 1'b0;
`ifdef RING_STEP_CHECK_EN
            pred_units      <= '0;
            pred_tens       <= '0;
            accept_bad      <= 1'b0;
`endif
        end else begin
            o_units_set0    <= 1'b0;
            o_units_advance <= 1'b0;
            o_tens_set0     <= 1'b0;
            o_tens_advance  <= 1'b0;
            o_done          <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        op_q         <= op_t'(i_cmd_op);
                        remaining    <= i_cmd_arg[6:0];
                        pulse_cnt    <= '0;
                        target_tens  <= i_cmd_arg[9:5];
                        target_units <= i_cmd_arg[4:0];
                        o_error      <= 1'b0;
                        o_cmd_ready  <= 1'b0;
                        o_busy       <= 1'b1;
                        state        <= S_EVAL;
`ifdef RING_STEP_CHECK_EN
                        pred_units   <= i_units;
                        pred_tens    <= i_tens;
                        accept_bad   <= !(is_2of5(i_units) && is_2of5(i_tens));
`endif
                    end
                end

                S_EVAL: begin
`ifdef RING_STEP_CHECK_EN
                    if (accept_bad) begin
                        o_error <= 1'b1;
                        state   <= S_DONE;
                    end else
`endif
                    begin
                        case (op_q)
                            OP_CLEAR: begin
                                o_units_set0 <= 1'b1;
                                o_tens_set0  <= 1'b1;
                                state        <= S_CLR;
                            end
                            OP_STEP: begin
                                if (remaining == '0) begin
                                    state <= S_DONE;
                                end else begin
                                    o_units_advance <= 1'b1;
                                    o_tens_advance  <= (i_units == CODE9);
                                    state           <= S_PULSE;
                                end
                            end
                            OP_SEEK: begin
                                if (!(is_2of5(target_units) && is_2of5(target_tens))) begin
                                    o_error <= 1'b1;
                                    state   <= S_DONE;
                                end else if ({i_tens, i_units} == {target_tens, target_units}) begin
                                    state <= S_DONE;
                                end else if (pulse_cnt == PW'(SEEK_LIMIT)) begin
                                    o_error <= 1'b1;
                                    state   <= S_DONE;
                                end else begin
                                    o_units_advance <= 1'b1;
                                    o_tens_advance  <= (i_units == CODE9);
                                    state           <= S_PULSE;
                                end
                            end
                            default: state <= S_DONE;
                        endcase
                    end
                end

                S_PULSE: begin
                    if (op_q == OP_STEP) begin
                        remaining <= remaining - 7'd1;
                    end
                    if (op_q == OP_SEEK) begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
`ifdef RING_STEP_CHECK_EN
                    pred_units <= next_code(pred_units);
                    if (o_tens_advance) begin
                        pred_tens <= next_code(pred_tens);
                    end
`endif
                    state <= S_WAIT;
                end

                S_WAIT: begin
`ifdef RING_STEP_CHECK_EN
                    if (!is_2of5(i_units) || !is_2of5(i_tens) ||
                        i_units != pred_units || i_tens != pred_tens) begin
                        o_error <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= S_EVAL;
                    end
`else
                    state <= S_EVAL;
`endif
                end

                S_CLR: begin
                    state <= S_CWAIT;
                end

                S_CWAIT: begin
`ifdef RING_STEP_CHECK_EN
                    if (i_units != CODE0 || i_tens != CODE0) begin
                        o_error <= 1'b1;
                    end
`endif
                    state <= S_DONE;
                end

                S_DONE: begin
                    o_done      <= 1'b1;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= S_IDLE;
                end

                default: begin
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
